// File: rtl/nibble_serial_adder_ctrl.sv
// Purpose : WIDTH-bit add (optionally subtract) done one nibble per cycle, LSB
//           first, through a single shared 4-bit adder with a registered carry.
// Latency : start accepted at edge T -> done pulses in the cycle after T+NIBBLES.
// Backpr. : none; start is ignored while busy (no queueing). A start during
//           the done cycle is accepted, so operations can run back to back.
//
// Ports:
//   clk    - clock; all state changes on the rising edge
//   reset  - synchronous, active-high; aborts any operation in flight
//   start  - request; accepted only when not busy (IDLE or DONE)
//   a, b   - WIDTH-bit operands, sampled on the accepting edge
//   c_in   - carry into nibble 0, sampled on the accepting edge
//   sub    - (only with ADDSEQ_SUB_EN) 1 = compute a - b, c_out=1 means no borrow
//   busy   - high while nibbles are being processed
//   done   - one-cycle pulse, sum/c_out valid
//   sum    - result, held from done until the next accepted start
//   c_out  - carry out of the top nibble, held with sum
//
// Optional feature macro: ADDSEQ_SUB_EN (adds the sub port and subtraction).
// WIDTH must be a multiple of 4 and at least 4.

// 4-bit ripple adder shared by the sequencer; purely combinational.
module adder (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       c_in,
  output logic [3:0] out,
  output logic       c_out
);
  assign {c_out, out} = {1'b0, x} + {1'b0, y} + {4'b0000, c_in};
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef ADDSEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_busy;
  logic               r_done;

  logic [3:0]         w_x;
  logic [3:0]         w_y;
  logic [3:0]         w_nib_sum;
  logic               w_nib_cout;
  logic               w_accept;

  // Adder sees only registered operands/carry, so a/b never reach the outputs
  // combinationally.
  assign w_x = r_a[r_idx*4 +: 4];
  assign w_y = r_b[r_idx*4 +: 4];

  adder u_adder (
    .x     (w_x),
    .y     (w_y),
    .c_in  (r_carry),
    .out   (w_nib_sum),
    .c_out (w_nib_cout)
  );

  // A new request is taken whenever no operation is in flight.
  assign w_accept = start && (r_state != S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (w_accept) begin
      // sum/c_out are left alone here; the first RUN edge starts overwriting.
      r_a     <= a;
`ifdef ADDSEQ_SUB_EN
      // Subtract as a + ~b + 1; c_in is irrelevant when subtracting.
      r_b     <= sub ? ~b : b;
      r_carry <= sub | c_in;
`else
      r_b     <= b;
      r_carry <= c_in;
`endif
      r_idx   <= '0;
      r_state <= S_RUN;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
        S_RUN: begin
          r_sum[r_idx*4 +: 4] <= w_nib_sum;
          r_carry             <= w_nib_cout;
          if (r_idx == LAST_IDX) begin
            r_cout  <= w_nib_cout;
            r_idx   <= '0;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef ADDSEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of expected {c_out, sum}, pushed when a start is driven.
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
`ifdef ADDSEQ_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  // Drive one start cycle and queue its expected result. Leaves time just
  // after the accepting edge, with the inputs scrambled.
  task automatic do_start(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic tsub);
    logic [W:0] e;
    start = 1'b1; a = ta; b = tb_; c_in = tc;
`ifdef ADDSEQ_SUB_EN
    sub = tsub;
    if (tsub) e = {1'b0, ta} + {1'b0, ~tb_} + (W+1)'(1);
    else      e = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
`else
    e = {1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc};
    if (tsub) e = 'x;
`endif
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
  endtask

  // Counts falling edges until done is seen (bounded); returns the count and
  // how many of those edges saw busy high. Ends on the done cycle's negedge.
  task automatic wait_done(output int lat, output int nbusy, output bit seen);
    lat = 0; nbusy = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (busy) nbusy++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef ADDSEQ_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (c_out !== 1'b0) begin failures++; $display("FAIL reset_cout got=%b exp=0", c_out); end
    @(posedge clk); #1;
  endtask

  // Runs one op from IDLE and checks latency, busy length, result, pulse width.
  task automatic test_op(input string name, input logic [W-1:0] ta,
                         input logic [W-1:0] tb_, input logic tc, input logic tsub);
    int lat, nb; bit seen; logic [W:0] e;
    do_start(ta, tb_, tc, tsub);
    wait_done(lat, nb, seen);
    checks++; if (!seen) begin failures++; $display("FAIL %s_done_seen got=0 exp=1", name); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL %s_latency got=%0d exp=5", name, lat); end
    checks++; if (nb !== 4) begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=4", name, nb); end
    if (sb.size() == 0) begin
      checks++; failures++; $display("FAIL %s_sb_empty got=empty exp=entry", name);
    end else begin
      e = sb.pop_front();
      checks++; if (sum !== e[W-1:0]) begin failures++; $display("FAIL %s_sum got=%h exp=%h", name, sum, e[W-1:0]); end
      checks++; if (c_out !== e[W]) begin failures++; $display("FAIL %s_cout got=%b exp=%b", name, c_out, e[W]); end
    end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL %s_done_pulse got=%b exp=0", name, done); end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore_start();
    int lat, nb; bit seen; logic [W:0] e;
    do_start(16'h0F0F, 16'h0101, 1'b0, 1'b0);
    start = 1'b1; a = 16'h1111; b = 16'h1111;   // during RUN: must be dropped
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nb, seen);
    checks++; if (!seen) begin failures++; $display("FAIL ign_done_seen got=0 exp=1"); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL ign_latency got=%0d exp=4", lat); end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++; if (sum !== e[W-1:0]) begin failures++; $display("FAIL ign_sum got=%h exp=%h", sum, e[W-1:0]); end
    checks++; if (c_out !== e[W]) begin failures++; $display("FAIL ign_cout got=%b exp=%b", c_out, e[W]); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL ign_extra_op got=done%b/busy%b exp=0/0", done, busy); end
      checks++; if (sum !== 16'h1010) begin failures++; $display("FAIL ign_hold_sum got=%h exp=1010", sum); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, nb; bit seen; logic [W:0] e;
    do_start(16'h1234, 16'h1111, 1'b1, 1'b0);
    wait_done(lat, nb, seen);
    checks++; if (!seen) begin failures++; $display("FAIL b2b_first_done got=0 exp=1"); end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++; if (sum !== e[W-1:0]) begin failures++; $display("FAIL b2b_first_sum got=%h exp=%h", sum, e[W-1:0]); end
    // Still in the done cycle: raise start for the next op.
    do_start(16'h000F, 16'h0001, 1'b0, 1'b0);
    wait_done(lat, nb, seen);
    checks++; if (!seen) begin failures++; $display("FAIL b2b_second_done got=0 exp=1"); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
    e = (sb.size() != 0) ? sb.pop_front() : 'x;
    checks++; if (sum !== e[W-1:0]) begin failures++; $display("FAIL b2b_sum got=%h exp=%h", sum, e[W-1:0]); end
    checks++; if (c_out !== e[W]) begin failures++; $display("FAIL b2b_cout got=%b exp=%b", c_out, e[W]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    do_start(16'h8888, 16'h8888, 1'b0, 1'b0);
    @(posedge clk); #1;          // now in the 2nd RUN cycle
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb.pop_back());        // aborted op yields no result
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_done got=%b exp=0", done); end
    checks++; if (sum !== '0) begin failures++; $display("FAIL rst_mid_sum got=%h exp=0000", sum); end
    checks++; if (c_out !== 1'b0) begin failures++; $display("FAIL rst_mid_cout got=%b exp=0", c_out); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_mid_late_done got=1 exp=0 cycle=%0d", i); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_op("basic",   16'h1234, 16'h4321, 1'b0, 1'b0);
    test_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
    test_op("cin",     16'hFFFF, 16'h0000, 1'b1, 1'b0);
    test_op("max",     16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    for (int i = 0; i < 4; i++)
      test_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'b0);
`ifdef ADDSEQ_SUB_EN
    test_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1);
    test_op("sub_nobor",  16'h0007, 16'h0005, 1'b0, 1'b1);
    test_op("sub_cin_ign", 16'h0007, 16'h0005, 1'b1, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
